hyperbus_wb_bridge: RTL

- Wishbone B4 classic slave, 32-bit data. Sits directly upstream of the hyperbus leader controller and drives its request side.
- Splits each 32-bit access into 16-bit HyperBus words: two words for memory space, one word for register space.
- Holds wrq/rrq for the whole burst, consumes ready/valid, then returns one Wishbone ack (or err).

---
 rtl/hyperbus_wb_bridge.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_wb_bridge
// Purpose  : Wishbone B4 classic slave that splits 32-bit accesses into
//            16-bit HyperBus words for the hyperbus leader controller.
// Option   : HYPERBUS_WB_TIMEOUT_EN enables the ready/valid burst timeout.
// Revision : 1.0 - initial release
// ============================================================================
module hyperbus_wb_bridge #(
    parameter int WB_ADDR_WIDTH  = 24,
    parameter int HB_ADDR_LENGTH = 32,
    parameter int REG_SPACE_BIT  = 23,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [WB_ADDR_WIDTH-1:0]  wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [HB_ADDR_LENGTH-1:0] hb_adr_o,
    output logic [15:0]               hb_dat_o,
    output logic [1:0]                hb_mask_o,
    output logic                      hb_reg_space_o,
    output logic                      hb_wrq_o,
    output logic                      hb_rrq_o,
    input  logic [15:0]               hb_dat_i,
    input  logic                      hb_ready_i,
    input  logic                      hb_valid_i
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (GAP_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("hyperbus_wb_bridge: GAP_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]               state_q, state_d;
    logic [GAP_W-1:0]         gap_q;
    logic [31:0]              dat_q;
    logic [3:0]               sel_q;
    logic                     reg_q, word_q, abort_q;
    logic [15:0]              rd_lo_q;
    logic [31:0]              wb_dat_q;
    logic [HB_ADDR_LENGTH-1:0] hb_adr_q;
    logic [15:0]              hb_dat_q;
    logic [1:0]               hb_mask_q;
    logic                     hb_reg_q, hb_wrq_q, hb_rrq_q;

    logic                     accept, busy, last_word, timeout_hit, to_err;
    logic [WB_ADDR_WIDTH-2:0] word_adr;
    logic                     unused_adr_lsb;

    assign unused_adr_lsb = ^wb_adr_i[1:0];

    // Byte address to 16-bit word address; the space-select bit never reaches the bus.
    always_comb begin
        word_adr = {wb_adr_i[WB_ADDR_WIDTH-1:2], 1'b0};
        word_adr[REG_SPACE_BIT-1] = 1'b0;
    end

    assign accept    = (state_q == S_IDLE) && (gap_q == '0) && wb_cyc_i && wb_stb_i;
    assign busy      = (state_q == S_WRITE) || (state_q == S_READ);
    assign last_word = reg_q | word_q;

`ifdef HYPERBUS_WB_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W    = (TO_BITS > 8) ? TO_BITS : 8;

    logic [TO_W-1:0] to_cnt_q;
    logic            to_err_q;
    logic            progress;

    assign progress    = ((state_q == S_WRITE) && hb_ready_i) || ((state_q == S_READ) && hb_valid_i);
    assign timeout_hit = busy && !progress && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign to_err      = to_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (accept || progress) begin
                to_cnt_q <= '0;
            end else if (busy) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (accept) begin
                to_err_q <= 1'b0;
            end else if (timeout_hit) begin
                to_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = wb_we_i ? S_WRITE : S_READ;
            S_WRITE: if (timeout_hit || (hb_ready_i && last_word)) state_d = S_DONE;
            S_READ:  if (timeout_hit || (hb_valid_i && last_word)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // A master that aborted mid-burst may already be on its next cycle; it must not see this ack.
    always_comb begin
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        if ((state_q == S_DONE) && wb_cyc_i && wb_stb_i && !abort_q) begin
            wb_err_o = to_err;
            wb_ack_o = !to_err;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_q     <= GAP_RELOAD;
            dat_q     <= '0;
            sel_q     <= '0;
            reg_q     <= 1'b0;
            word_q    <= 1'b0;
            abort_q   <= 1'b0;
            rd_lo_q   <= '0;
            wb_dat_q  <= '0;
            hb_adr_q  <= '0;
            hb_dat_q  <= '0;
            hb_mask_q <= '0;
            hb_reg_q  <= 1'b0;
            hb_wrq_q  <= 1'b0;
            hb_rrq_q  <= 1'b0;
        end else begin
            hb_wrq_q <= (state_d == S_WRITE);
            hb_rrq_q <= (state_d == S_READ);

            if (state_q == S_DONE) begin
                gap_q <= GAP_RELOAD;
            end else if ((state_q == S_IDLE) && (gap_q != '0)) begin
                gap_q <= gap_q - GAP_W'(1);
            end

            if (accept) begin
                dat_q     <= wb_dat_i;
                sel_q     <= wb_sel_i;
                reg_q     <= wb_adr_i[REG_SPACE_BIT];
                word_q    <= 1'b0;
                abort_q   <= 1'b0;
                hb_adr_q  <= HB_ADDR_LENGTH'(word_adr);
                hb_reg_q  <= wb_adr_i[REG_SPACE_BIT];
                hb_dat_q  <= wb_dat_i[15:0];
                hb_mask_q <= wb_adr_i[REG_SPACE_BIT] ? 2'b00 : ~wb_sel_i[1:0];
            end else if (busy && !wb_cyc_i) begin
                abort_q <= 1'b1;
            end

            if ((state_q == S_WRITE) && hb_ready_i && !last_word) begin
                word_q    <= 1'b1;
                hb_dat_q  <= dat_q[31:16];
                hb_mask_q <= ~sel_q[3:2];
            end

            if ((state_q == S_READ) && hb_valid_i) begin
                if (!last_word) begin
                    rd_lo_q <= hb_dat_i;
                    word_q  <= 1'b1;
                end else begin
                    wb_dat_q <= reg_q ? {16'h0000, hb_dat_i} : {hb_dat_i, rd_lo_q};
                end
            end
        end
    end

    assign wb_dat_o       = wb_dat_q;
    assign hb_adr_o       = hb_adr_q;
    assign hb_dat_o       = hb_dat_q;
    assign hb_mask_o      = hb_mask_q;
    assign hb_reg_space_o = hb_reg_q;
    assign hb_wrq_o       = hb_wrq_q;
    assign hb_rrq_o       = hb_rrq_q;

endmodule
`default_nettype wire
